// File: rtl/dmem_axi_responder.sv
// Single-beat AXI-style memory responder: independent read and write FSMs over a
// byte-writable 32-bit word array, with programmable read and write latencies.
module dmem_axi_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 1,
  parameter int          WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [3:0]  rid,
  output logic        rlast,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid
);

  localparam int          IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  RD_CNT   = 4'(RD_LAT - 1);
  localparam logic [3:0]  WR_CNT   = 4'(WR_LAT - 1);
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;
  localparam logic [1:0]  DECERR   = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} rstate_t;
  typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_LAT, W_RESP} wstate_t;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  function automatic logic f_in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < ADDR_END);
  endfunction

  function automatic logic [IDXW-1:0] f_idx(input logic [31:0] a);
    return IDXW'((a - ADDR_BASE) >> 2);
  endfunction

  function automatic logic [1:0] f_resp(input logic [31:0] a, input logic bad);
    if (!f_in_range(a)) return DECERR;
    else if (bad)       return SLVERR;
    else                return OKAY;
  endfunction

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------- read channel ----------------
  rstate_t         r_rstate, w_rnext;
  logic [31:0]     r_araddr;
  logic [3:0]      r_arid;
  logic [7:0]      r_arlen;
  logic [3:0]      r_rcnt;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            w_ar_fire, w_r_fire, w_rd_sample;
  logic [31:0]     w_rd_addr;
  logic [7:0]      w_rd_len;
  logic [1:0]      w_rd_resp;
  logic [IDXW-1:0] w_rd_idx;

  assign w_ar_fire   = arvalid & arready;
  assign w_r_fire    = rvalid & rready;
  // With RD_LAT=1 the array is sampled on the handshake edge itself, straight from the bus.
  assign w_rd_addr   = (r_rstate == R_IDLE) ? araddr : r_araddr;
  assign w_rd_len    = (r_rstate == R_IDLE) ? arlen  : r_arlen;
  assign w_rd_resp   = f_resp(w_rd_addr, w_rd_len != 8'd0);
  assign w_rd_idx    = f_idx(w_rd_addr);
  assign w_rd_sample = (w_ar_fire && (RD_LAT == 1)) || ((r_rstate == R_LAT) && (r_rcnt == 4'd1));

  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready = !rst;
        if (w_ar_fire) w_rnext = (RD_LAT == 1) ? R_RESP : R_LAT;
      end
      R_LAT:   if (r_rcnt == 4'd1) w_rnext = R_RESP;
      R_RESP: begin
        rvalid = !rst;
        if (w_r_fire) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_arid   <= '0;
      r_arlen  <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else begin
      if (w_ar_fire) begin
        r_araddr <= araddr;
        r_arid   <= arid;
        r_arlen  <= arlen;
        r_rcnt   <= RD_CNT;
      end else if (r_rstate == R_LAT) begin
        r_rcnt <= r_rcnt - 4'd1;
      end
      if (w_rd_sample) begin
        r_rdata <= (w_rd_resp == OKAY) ? r_mem[w_rd_idx] : 32'd0;
        r_rresp <= w_rd_resp;
      end
    end
  end

  assign rdata = rst ? 32'd0 : r_rdata;
  assign rresp = rst ? OKAY  : r_rresp;
  assign rid   = rst ? 4'd0  : r_arid;
  assign rlast = rvalid;

  // ---------------- write channel ----------------
  wstate_t         r_wstate, w_wnext;
  logic [31:0]     r_awaddr;
  logic [3:0]      r_awid;
  logic [7:0]      r_awlen;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_wlast;
  logic [3:0]      r_wcnt;
  logic [1:0]      r_bresp;
  logic            w_aw_fire, w_w_fire, w_b_fire, w_accept, w_commit;
  logic [31:0]     w_wr_addr, w_wr_data;
  logic [7:0]      w_wr_len;
  logic [3:0]      w_wr_strb;
  logic            w_wr_last;
  logic [1:0]      w_wr_resp;
  logic [IDXW-1:0] w_wr_idx;

  assign w_aw_fire = awvalid & awready;
  assign w_w_fire  = wvalid & wready;
  assign w_b_fire  = bvalid & bready;
  assign w_accept  = ((r_wstate == W_IDLE)    && w_aw_fire && w_w_fire) ||
                     ((r_wstate == W_HAVE_AW) && w_w_fire) ||
                     ((r_wstate == W_HAVE_W)  && w_aw_fire);

  // Whichever half arrives this cycle comes from the bus, the other from its holding register.
  assign w_wr_addr = w_aw_fire ? awaddr : r_awaddr;
  assign w_wr_len  = w_aw_fire ? awlen  : r_awlen;
  assign w_wr_data = w_w_fire  ? wdata  : r_wdata;
  assign w_wr_strb = w_w_fire  ? wstrb  : r_wstrb;
  assign w_wr_last = w_w_fire  ? wlast  : r_wlast;
  assign w_wr_resp = f_resp(w_wr_addr, (w_wr_len != 8'd0) || !w_wr_last);
  assign w_wr_idx  = f_idx(w_wr_addr);
  assign w_commit  = !rst && ((w_accept && (WR_LAT == 1)) ||
                              ((r_wstate == W_LAT) && (r_wcnt == 4'd1)));

  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext = r_wstate;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready = !rst;
        wready  = !rst;
        if (w_accept)       w_wnext = (WR_LAT == 1) ? W_RESP : W_LAT;
        else if (w_aw_fire) w_wnext = W_HAVE_AW;
        else if (w_w_fire)  w_wnext = W_HAVE_W;
      end
      W_HAVE_AW: begin
        wready = !rst;
        if (w_accept) w_wnext = (WR_LAT == 1) ? W_RESP : W_LAT;
      end
      W_HAVE_W: begin
        awready = !rst;
        if (w_accept) w_wnext = (WR_LAT == 1) ? W_RESP : W_LAT;
      end
      W_LAT:   if (r_wcnt == 4'd1) w_wnext = W_RESP;
      W_RESP: begin
        bvalid = !rst;
        if (w_b_fire) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr <= '0;
      r_awid   <= '0;
      r_awlen  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wlast  <= 1'b0;
      r_wcnt   <= '0;
      r_bresp  <= OKAY;
    end else begin
      if (w_aw_fire) begin
        r_awaddr <= awaddr;
        r_awid   <= awid;
        r_awlen  <= awlen;
      end
      if (w_w_fire) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
        r_wlast <= wlast;
      end
      if (w_accept)                 r_wcnt <= WR_CNT;
      else if (r_wstate == W_LAT)   r_wcnt <= r_wcnt - 4'd1;
      if (w_commit)                 r_bresp <= w_wr_resp;
    end
  end

  // Array is never reset; a read sampling the same edge sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_commit && (w_wr_resp == OKAY)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  assign bresp = rst ? OKAY : r_bresp;
  assign bid   = rst ? 4'd0 : r_awid;

endmodule

// File: tb/tb_dmem_axi_responder.sv
// Directed bench: u0 runs with unit latencies, u4 with RD_LAT=3/WR_LAT=4 for
// latency counting and mid-transaction reset; both share the bus inputs.
module tb_dmem_axi_responder;
  logic        clk, rst, rst4;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  arid, awid, wstrb;
  logic [7:0]  arlen, awlen;

  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [3:0]  rid, bid;

  logic        arready4, rvalid4, rlast4, awready4, wready4, bvalid4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4, bresp4;
  logic [3:0]  rid4, bid4;

  int npass = 0, nfail = 0, ntot = 0;

  dmem_axi_responder u0 (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  dmem_axi_responder #(.RD_LAT(3), .WR_LAT(4)) u4 (
    .clk(clk), .rst(rst4),
    .arvalid(arvalid), .arready(arready4), .araddr(araddr), .arid(arid), .arlen(arlen),
    .rvalid(rvalid4), .rready(rready), .rdata(rdata4), .rresp(rresp4), .rid(rid4), .rlast(rlast4),
    .awvalid(awvalid), .awready(awready4), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready4), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid4), .bready(bready), .bresp(bresp4), .bid(bid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk);     endtask

  // AW and W presented together to u0 (WR_LAT=1): bvalid the next cycle.
  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input logic [31:0] d, input logic [3:0] s,
                    input logic last, input logic [1:0] exp_resp);
    step;
    awvalid = 1; awaddr = a; awid = id; awlen = len;
    wvalid = 1; wdata = d; wstrb = s; wlast = last; bready = 1;
    smp;  chk({tag, " aw/w ready"}, {30'd0, awready, wready}, 32'd3);
    step; awvalid = 0; wvalid = 0;
    smp;  chk({tag, " bvalid"}, {31'd0, bvalid}, 32'd1);
          chk({tag, " bresp"},  {30'd0, bresp},  {30'd0, exp_resp});
          chk({tag, " bid"},    {28'd0, bid},    {28'd0, id});
  endtask

  // Single read on u0 (RD_LAT=1) with rready high: rvalid the cycle after AR.
  task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input logic [31:0] exp_d, input logic [1:0] exp_resp);
    step;
    arvalid = 1; araddr = a; arid = id; arlen = len; rready = 1;
    smp;  chk({tag, " arready"}, {31'd0, arready}, 32'd1);
    step; arvalid = 0;
    smp;  chk({tag, " rvalid"}, {31'd0, rvalid}, 32'd1);
          chk({tag, " rdata"},  rdata, exp_d);
          chk({tag, " rresp"},  {30'd0, rresp}, {30'd0, exp_resp});
          chk({tag, " rid/rlast"}, {27'd0, rid, rlast}, {27'd0, id, 1'b1});
  endtask

  initial begin
    rst = 1; rst4 = 1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; rready = 0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;

    // Reset state
    step; step;
    smp; chk("rst handshakes", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'd0);
         chk("rst rdata", rdata, 32'd0);
         chk("rst resp/ids", {20'd0, rresp, bresp, rid, bid}, 32'd0);
    step; rst = 0;
    smp; chk("post-rst readies", {29'd0, arready, awready, wready}, 32'd7);

    // Same-cycle AW/W then readback
    wr("w31", 32'h8000_0010, 4'd5, 8'd0, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00);
    rd("r31", 32'h8000_0010, 4'd9, 8'd0, 32'hDEAD_BEEF, 2'b00);

    // W first, AW three cycles later; partial strobe merge
    wr("w32 init", 32'h8000_0020, 4'd1, 8'd0, 32'h1122_3344, 4'hF, 1'b1, 2'b00);
    step; wvalid = 1; wdata = 32'h0000_AB00; wstrb = 4'b0010; wlast = 1;
    smp;  chk("w32 W ready", {31'd0, wready}, 32'd1);
    step; wvalid = 0;
    smp;  chk("w32 have_w ready", {30'd0, awready, wready}, 32'd2);
          chk("w32 no early b", {31'd0, bvalid}, 32'd0);
    step;
    smp;  chk("w32 still no b", {31'd0, bvalid}, 32'd0);
    step; awvalid = 1; awaddr = 32'h8000_0020; awid = 4'd3; awlen = 0;
    smp;  chk("w32 AW ready", {31'd0, awready}, 32'd1);
    step; awvalid = 0;
    smp;  chk("w32 bvalid t+1", {31'd0, bvalid}, 32'd1);
          chk("w32 bid/bresp", {26'd0, bid, bresp}, {26'd0, 4'd3, 2'b00});
    rd("r32", 32'h8000_0020, 4'd2, 8'd0, 32'h1122_AB44, 2'b00);

    // Address window edges and error responses
    wr("w33 base",  32'h8000_0000, 4'd0, 8'd0, 32'h0101_0101, 4'hF, 1'b1, 2'b00);
    wr("w33 top",   32'h8000_0FFC, 4'd1, 8'd0, 32'hCAFE_F00D, 4'hF, 1'b1, 2'b00);
    rd("r33 top",   32'h8000_0FFC, 4'd1, 8'd0, 32'hCAFE_F00D, 2'b00);
    rd("r33 below", 32'h7FFF_FFFC, 4'd4, 8'd0, 32'd0, 2'b11);
    wr("w33 above", 32'h8000_1000, 4'd6, 8'd0, 32'hBAD0_BAD0, 4'hF, 1'b1, 2'b11);
    rd("r33 alias", 32'h8000_0000, 4'd0, 8'd0, 32'h0101_0101, 2'b00);
    rd("r33 above", 32'h8000_1000, 4'd7, 8'd0, 32'd0, 2'b11);
    rd("r33 arlen", 32'h8000_0010, 4'd8, 8'd3, 32'd0, 2'b10);
    rd("r33 after", 32'h8000_0010, 4'd8, 8'd0, 32'hDEAD_BEEF, 2'b00);
    rd("r33 prio",  32'h7FFF_FFFC, 4'd2, 8'd3, 32'd0, 2'b11);
    wr("w33 awlen", 32'h8000_0010, 4'd2, 8'd1, 32'h0, 4'hF, 1'b1, 2'b10);
    wr("w33 wlast", 32'h8000_0010, 4'd3, 8'd0, 32'h0, 4'hF, 1'b0, 2'b10);
    wr("w33 strb0", 32'h8000_0010, 4'd4, 8'd0, 32'h0, 4'h0, 1'b1, 2'b00);
    rd("r33 intact", 32'h8000_0010, 4'd5, 8'd0, 32'hDEAD_BEEF, 2'b00);

    // R backpressure for 6 cycles
    step; arvalid = 1; araddr = 32'h8000_0020; arid = 4'd7; arlen = 0; rready = 0;
    smp;  chk("r34 arready", {31'd0, arready}, 32'd1);
    step; arvalid = 0;
    for (int i = 0; i < 6; i++) begin
      smp;  chk($sformatf("r34 hold%0d", i), {26'd0, rvalid, arready, rid}, {26'd0, 1'b1, 1'b0, 4'd7});
            chk($sformatf("r34 data%0d", i), rdata, 32'h1122_AB44);
      step;
    end
    rready = 1;
    smp;  chk("r34 rvalid", {31'd0, rvalid}, 32'd1);
    step; rready = 0;
    smp;  chk("r34 after fire", {30'd0, arready, rvalid}, 32'd2);

    // Write commit and read sample on the same edge
    wr("w36 old", 32'h8000_0030, 4'd1, 8'd0, 32'h1, 4'hF, 1'b1, 2'b00);
    step;
    arvalid = 1; araddr = 32'h8000_0030; arid = 4'd1; arlen = 0; rready = 1;
    awvalid = 1; awaddr = 32'h8000_0030; awid = 4'd2; awlen = 0;
    wvalid = 1; wdata = 32'h2; wstrb = 4'hF; wlast = 1; bready = 1;
    smp;  chk("r36 readies", {29'd0, arready, awready, wready}, 32'd7);
    step; arvalid = 0; awvalid = 0; wvalid = 0;
    smp;  chk("r36 rdata old", rdata, 32'h1);
          chk("r36 valids", {30'd0, rvalid, bvalid}, 32'd3);
    rd("r36 new", 32'h8000_0030, 4'd3, 8'd0, 32'h2, 2'b00);

    // Switch to u4: hold u0 in reset, outputs must read back as zero
    step; rst = 1; rst4 = 0;
    smp;  chk("u0 rst rdata", rdata, 32'd0);
          chk("u0 rst valids", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'd0);
          chk("u4 readies", {29'd0, arready4, awready4, wready4}, 32'd7);

    // WR_LAT=4: bvalid exactly at t+4
    step; awvalid = 1; awaddr = 32'h8000_0040; awid = 4'd2; awlen = 0;
          wvalid = 1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wlast = 1; bready = 1;
    smp;  chk("u4 w ready", {30'd0, awready4, wready4}, 32'd3);
    step; awvalid = 0; wvalid = 0;
    for (int i = 1; i < 4; i++) begin
      smp;  chk($sformatf("u4 no b t+%0d", i), {31'd0, bvalid4}, 32'd0);
      step;
    end
    smp;  chk("u4 b t+4", {25'd0, bvalid4, bid4, bresp4}, {25'd0, 1'b1, 4'd2, 2'b00});

    // RD_LAT=3: rvalid exactly at c+3
    step; arvalid = 1; araddr = 32'h8000_0040; arid = 4'd6; arlen = 0; rready = 1;
    smp;  chk("u4 arready", {31'd0, arready4}, 32'd1);
    step; arvalid = 0;
    for (int i = 1; i < 3; i++) begin
      smp;  chk($sformatf("u4 no r c+%0d", i), {31'd0, rvalid4}, 32'd0);
      step;
    end
    smp;  chk("u4 r c+3", {27'd0, rvalid4, rid4}, {27'd0, 1'b1, 4'd6});
          chk("u4 rdata", rdata4, 32'hA5A5_A5A5);

    // Reset during W_LAT discards the write
    step; awvalid = 1; wvalid = 1; wdata = 32'h5A5A_5A5A; awid = 4'd9;
    smp;  chk("u4 rst-w ready", {30'd0, awready4, wready4}, 32'd3);
    step; awvalid = 0; wvalid = 0; rst4 = 1;
    smp;  chk("u4 in rst", {29'd0, awready4, wready4, bvalid4}, 32'd0);
    step; rst4 = 0;
    smp;  chk("u4 post rst", {29'd0, awready4, wready4, bvalid4}, 32'd6);
    for (int i = 0; i < 3; i++) begin
      step;
      smp; chk($sformatf("u4 no b %0d", i), {31'd0, bvalid4}, 32'd0);
    end
    step; arvalid = 1; araddr = 32'h8000_0040; arid = 4'd1; rready = 1;
    smp;  chk("u4 rd arready", {31'd0, arready4}, 32'd1);
    step; arvalid = 0;
    step; step;
    smp;  chk("u4 word kept", rdata4, 32'hA5A5_A5A5);
          chk("u4 rd rvalid", {31'd0, rvalid4}, 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
